// File: rtl/mem_access_ctrl_pkg.sv
// Shared types, funct3 encodings and store lane helpers for the MEM-stage access controller.
package mem_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    if (is_store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Size is carried in funct3[1:0]: 01 = half, 10 = word.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] data);
    case (f3)
      F3_B:    return {4{data[7:0]}};
      F3_H:    return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic [3:0] store_wstrb(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B:    return 4'b0001 << off;
      F3_H:    return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_extend.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_off)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_W:    o_data = i_word;
      F3_BU:   o_data = {24'h0, w_byte};
      F3_HU:   o_data = {16'h0, w_half};
      default: o_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data memory sequencer: issues one bus request per legal load/store,
// stalls the pipeline until the response or a timeout, and returns extended load data.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter  int TIMEOUT = 255,
  localparam int TCNT_W  = $clog2(TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memWrtm,
  input  logic        readm,
  input  logic [2:0]  funct3m,
  input  logic [31:0] aluRsltm,
  input  logic [31:0] wrtDm,
  output logic        busValid,
  input  logic        busReady,
  output logic        busWe,
  output logic [31:0] busAddr,
  output logic [31:0] busWdata,
  output logic [3:0]  busWstrb,
  input  logic        rspValid,
  input  logic [31:0] rspData,
  output logic        memStall,
  output logic [31:0] readDatam,
  output logic        alignErr,
  output logic        busErr,
  output logic [1:0]  dbgState
);

  localparam logic [TCNT_W-1:0] LAST_CNT = TCNT_W'(TIMEOUT - 1);

  state_t             r_state;
  logic [TCNT_W-1:0]  r_cnt;
  logic [31:0]        r_data;
  logic [1:0]         r_off;
  logic [2:0]         r_f3;
  logic               r_tout;

  logic        w_acc;
  logic        w_go;
  logic        w_bad;
  logic [31:0] w_ext;

  assign w_acc = readm | memWrtm;
  assign w_go  = w_acc & f3_legal(funct3m, memWrtm) & ~misaligned(funct3m, aluRsltm[1:0]);
  assign w_bad = w_acc & ~w_go;

  // Request channel: a transfer happens on a cycle with busValid & busReady;
  // while busValid is high without busReady, all bus fields are held unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_data   <= '0;
      r_off    <= '0;
      r_f3     <= '0;
      r_tout   <= 1'b0;
      busValid <= 1'b0;
      busWe    <= 1'b0;
      busAddr  <= '0;
      busWdata <= '0;
      busWstrb <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_tout <= 1'b0;
          if (w_go) begin
            r_state  <= REQ;
            r_cnt    <= '0;
            r_off    <= aluRsltm[1:0];
            r_f3     <= funct3m;
            busValid <= 1'b1;
            busWe    <= memWrtm;
            busAddr  <= {aluRsltm[31:2], 2'b00};
            busWdata <= memWrtm ? store_wdata(funct3m, wrtDm) : 32'h0;
            busWstrb <= memWrtm ? store_wstrb(funct3m, aluRsltm[1:0]) : 4'h0;
          end
        end
        REQ: begin
          r_cnt <= r_cnt + 1'b1;
          // The budget check wins over a same-cycle accept: the access could not finish in time anyway.
          if (r_cnt == LAST_CNT) begin
            r_state  <= DONE;
            r_tout   <= 1'b1;
            r_data   <= '0;
            busValid <= 1'b0;
          end else if (busReady) begin
            r_state  <= WAIT;
            busValid <= 1'b0;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (rspValid) begin
            r_state <= DONE;
            if (!busWe) r_data <= rspData;
          end else if (r_cnt == LAST_CNT) begin
            r_state <= DONE;
            r_tout  <= 1'b1;
            r_data  <= '0;
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  load_extend u_load_extend (
    .i_word   (r_data),
    .i_off    (r_off),
    .i_funct3 (r_f3),
    .o_data   (w_ext)
  );

  assign memStall  = ~rst & (((r_state == IDLE) & w_go) | (r_state == REQ) | (r_state == WAIT));
  assign alignErr  = ~rst & (r_state == IDLE) & w_bad;
  assign busErr    = ~rst & (r_state == DONE) & r_tout;
  assign readDatam = (~rst && r_state == DONE && !r_tout && !busWe) ? w_ext : 32'h0;
  assign dbgState  = r_state;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences data-memory accesses for the MEM stage of the in-order 5-stage pipeline.
- Inputs:
  - control and datapath values registered by the EX/MEM pipeline register;
  - a valid/ready request channel and a response channel to a multi-cycle data memory.
- Responsibilities:
  - issues the request and holds the pipeline until the access completes;
  - flags misaligned, illegal and timed-out accesses;
  - returns size-extended load data to the writeback mux.

Parameters:
- TIMEOUT, 255, max cycles spent in REQ+WAIT before the access is abandoned (must be >=2).
- TCNT_W, $clog2(TIMEOUT+1), timeout counter width (derived, not overridden).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- memWrtm  in  1  store in MEM stage.
- readm  in  1  load in MEM stage.
- funct3m  in  3  access size/sign (RV32I load/store funct3).
- aluRsltm  in  32  byte address.
- wrtDm  in  32  store data (unshifted, low-aligned).
- busValid  out  1  request valid.
- busReady  in  1  memory accepts request.
- busWe  out  1  request is a write.
- busAddr  out  32  word address, {aluRsltm[31:2],2'b00}.
- busWdata  out  32  store data shifted into byte lanes.
- busWstrb  out  4  byte-lane write enables (0 for reads).
- rspValid  in  1  response/write-ack valid (one-cycle pulse).
- rspData  in  32  read word.
- memStall  out  1  hold PC, IF/ID, ID/EX, EX/MEM; bubble MEM/WB.
- readDatam  out  32  extended load data, valid in DONE cycle.
- alignErr  out  1  one-cycle pulse: misaligned or illegal funct3.
- busErr  out  1  one-cycle pulse: timeout.

Behaviour:
- Reset values:
  - state = IDLE, busValid = 0, busWe = 0, busAddr = 0, busWdata = 0, busWstrb = 0.
  - Timeout counter = 0, data register = 0.
  - memStall = 0, alignErr = 0, busErr = 0, readDatam = 0.
- Access present: acc = readm | memWrtm. If both are set, treat it as a store.
- Legal funct3:
  - loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu;
  - stores: 000 sb, 001 sh, 010 sw.
- Misalignment:
  - halfword: addr[0] = 1;
  - word: addr[1:0] != 0.
- Illegal or misaligned access in IDLE:
  - no bus request, memStall = 0, alignErr = 1 for that cycle, readDatam = 0;
  - the pipeline advances.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - legal acc: memStall = 1 (combinational, same cycle).
  - Next state is REQ, with busValid, busWe, busAddr, busWdata and busWstrb registered.
- REQ:
  - busValid = 1, memStall = 1; bus fields stable until accepted.
  - busValid & busReady: go to WAIT, drop busValid.
- WAIT:
  - memStall = 1.
  - rspValid: capture rspData (reads only) and go to DONE.
- DONE:
  - memStall = 0; readDatam is driven from the captured word.
  - Always returns to IDLE next cycle, so a held instruction never re-issues.
- Timeout:
  - counter clears on IDLE->REQ and increments each cycle in REQ/WAIT.
  - On reaching TIMEOUT: go to DONE with busErr = 1 and readDatam = 0; busValid drops.
- Response handling:
  - rspValid in IDLE, REQ or DONE is ignored (stale responses after reset or timeout).
  - Memory responds no earlier than the cycle after acceptance.
- Store lane mapping:
  - sb: wdata = {4{wrtDm[7:0]}}, wstrb = 4'b0001 << addr[1:0].
  - sh: wdata = {2{wrtDm[15:0]}}, wstrb = 4'b0011 << addr[1:0].
  - sw: wdata = wrtDm, wstrb = 4'b1111.
- Load extract: byte/half selected by addr[1:0]; lb/lh sign-extend, lbu/lhu zero-extend.
- Address and funct3 source: taken from a registered copy captured at IDLE->REQ, not from the live inputs.
- Minimum latency: 4 cycles IDLE->DONE when busReady is immediate and rspValid comes the next cycle.
- Stores also wait for the rspValid ack.
- Reset mid-operation:
  - any state -> IDLE next cycle; busValid deasserts and memStall drops.
  - The in-flight access is abandoned; the memory side must tolerate the dropped request.

Decomposition:
- Shared package mem_pkg:
  - state enum (IDLE/REQ/WAIT/DONE);
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - lane/strobe helper functions.
- One natural combinational sub-module, load_extend: inputs word, addr[1:0], funct3; output the 32-bit extended result.
- The FSM, counter and store formatting stay in mem_access_ctrl.

Test Plan:
- lw at addr 0x100, busReady immediate, rspValid+rspData = 0xDEADBEEF one cycle after accept -> memStall high 3 cycles; readDatam = 0xDEADBEEF in DONE; busWstrb = 0.
- lb at addr 0x103, rspData = 0x80FF_FFFF -> readDatam = 0xFFFFFF80; lbu same -> 0x00000080.
- sh at addr 0x102, wrtDm = 0x1234ABCD -> busWe = 1, busWdata = 0xABCDABCD, busWstrb = 4'b1100, busAddr = 0x100.
- lw at addr 0x101 -> alignErr pulse 1 cycle, no busValid, memStall never asserted.
- sw with busReady held low 3 cycles -> busValid and fields stable for 4 cycles; accepted on 4th; completes on ack.
- Load with no rspValid, TIMEOUT = 8 -> busErr pulse after 8 REQ+WAIT cycles; readDatam = 0; back to IDLE; a late rspValid is ignored.
- rst asserted while in WAIT -> IDLE next cycle, memStall = 0; following rspValid produces no effect.
